// File: rtl/arb_pkg.sv
// Shared definitions for the IF/MEM single-port memory arbiter.
package arb_pkg;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_BUSY = 2'd1,
        IF_BUSY  = 2'd2,
        IF_DROP  = 2'd3
    } arb_state_e;

    // Byte enables presented to memory on reads.
    localparam logic [3:0] BE_NONE = 4'b0000;

    // Saturating increment for the optional performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Memory acknowledge watchdog: counts unacknowledged busy cycles since the last grant and
// flags a timeout once MAX_WAIT such cycles have elapsed.
module arb_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,   // grant: restart the count
    input  logic busy_i,    // a memory transaction is outstanding
    input  logic ack_i,     // memory completion this cycle
    output logic timeout_o
);
    localparam int unsigned   CW   = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting;

    assign waiting   = busy_i & ~ack_i;
    // Fires on the MAX_WAIT-th busy cycle without an ack.
    assign timeout_o = waiting & (cnt_q == LAST);

    // Next count: clear on grant, advance while waiting, hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the IF fetch port and the MEM load/store
// port. MEM has priority; fetches can be aborted but an issued memory access always runs to
// ack (or timeout). Optional performance counters are enabled with `define ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_abort_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_be_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_ready_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              m_valid_o,
    output logic              m_we_o,
    output logic [3:0]        m_be_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic              m_ack_i,
    input  logic [DATA_W-1:0] m_rdata_i,
    output logic              stall_o,
    output logic              err_o
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       if_wait_cnt_o,
    output logic [31:0]       mem_wait_cnt_o,
    output logic [31:0]       conflict_cnt_o,
    output logic [31:0]       drop_cnt_o
`endif
);
    import arb_pkg::*;

    arb_state_e        state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic              m_we_q, m_we_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              err_q, err_d;

    logic              busy, timeout, done, grant_mem, grant_if;
    logic [DATA_W-1:0] resp_data;

    assign busy      = (state_q != IDLE);
    assign done      = busy & (m_ack_i | timeout);
    assign resp_data = m_ack_i ? m_rdata_i : '0;
    // A requester still holds its request during its own ready pulse; never re-grant it then.
    assign grant_mem = (state_q == IDLE) & mem_req_i & ~mem_ready_q;
    assign grant_if  = (state_q == IDLE) & ~grant_mem & if_req_i & ~if_abort_i & ~if_ready_q;
    assign err_d     = err_q | timeout;

    arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (grant_mem | grant_if),
        .busy_i    (busy),
        .ack_i     (m_ack_i),
        .timeout_o (timeout)
    );

    // Next-state, memory-side request registers and response pulses.
    always_comb begin
        state_d     = state_q;
        m_valid_d   = m_valid_q;
        m_we_d      = m_we_q;
        m_be_d      = m_be_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    m_valid_d = 1'b1;
                    m_we_d    = mem_we_i;
                    m_be_d    = mem_we_i ? mem_be_i : BE_NONE;
                    m_addr_d  = mem_addr_i;
                    m_wdata_d = mem_wdata_i;
                    state_d   = MEM_BUSY;
                end else if (grant_if) begin
                    m_valid_d = 1'b1;
                    m_we_d    = 1'b0;
                    m_be_d    = BE_NONE;
                    m_addr_d  = if_addr_i;
                    m_wdata_d = '0;
                    state_d   = IF_BUSY;
                end
            end
            MEM_BUSY: begin
                if (done) begin
                    m_valid_d   = 1'b0;
                    mem_ready_d = 1'b1;
                    if (!m_we_q) mem_rdata_d = resp_data;
                    state_d     = IDLE;
                end
            end
            IF_BUSY: begin
                // Abort wins over a same-cycle completion.
                if (if_abort_i) begin
                    if (done) begin
                        m_valid_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        state_d   = IF_DROP;
                    end
                end else if (done) begin
                    m_valid_d  = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = resp_data;
                    state_d    = IDLE;
                end
            end
            IF_DROP: begin
                if (done) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            m_valid_q   <= 1'b0;
            m_we_q      <= 1'b0;
            m_be_q      <= BE_NONE;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_valid_q   <= m_valid_d;
            m_we_q      <= m_we_d;
            m_be_q      <= m_be_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
        end
    end

    assign m_valid_o   = m_valid_q;
    assign m_we_o      = m_we_q;
    assign m_be_o      = m_be_q;
    assign m_addr_o    = m_addr_q;
    assign m_wdata_o   = m_wdata_q;
    assign if_ready_o  = if_ready_q;
    assign mem_ready_o = mem_ready_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign err_o       = err_q;
    // Gated by reset so every output reads 0 while reset is held.
    assign stall_o = rst_i & ((if_req_i & ~if_ready_q & ~if_abort_i) | (mem_req_i & ~mem_ready_q));

`ifdef ARB_PERF_EN
    logic [31:0] if_wait_q, mem_wait_q, conflict_q, drop_q;

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_wait_q  <= '0;
            mem_wait_q <= '0;
            conflict_q <= '0;
            drop_q     <= '0;
        end else begin
            if_wait_q  <= sat_inc(if_wait_q, if_req_i & ~if_ready_q);
            mem_wait_q <= sat_inc(mem_wait_q, mem_req_i & ~mem_ready_q);
            conflict_q <= sat_inc(conflict_q, (state_q == IDLE) & if_req_i & mem_req_i);
            drop_q     <= sat_inc(drop_q, (state_q == IF_BUSY) & (state_d == IF_DROP));
        end
    end

    assign if_wait_cnt_o  = if_wait_q;
    assign mem_wait_cnt_o = mem_wait_q;
    assign conflict_cnt_o = conflict_q;
    assign drop_cnt_o     = drop_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, a transaction-level reference model checked
// every cycle, and literal expectations for the key scenarios.
module tb_mem_port_arbiter;
    localparam int unsigned MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i, if_abort_i, if_ready_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        mem_req_i, mem_we_i, mem_ready_o;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic        m_valid_o, m_we_o, m_ack_i;
    logic [3:0]  m_be_o;
    logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
    logic        stall_o, err_o;
`ifdef ARB_PERF_EN
    logic [31:0] if_wait_cnt, mem_wait_cnt, conflict_cnt, drop_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_abort_i  (if_abort_i),
        .if_ready_o  (if_ready_o),
        .if_rdata_o  (if_rdata_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_be_i    (mem_be_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o),
        .m_valid_o   (m_valid_o),
        .m_we_o      (m_we_o),
        .m_be_o      (m_be_o),
        .m_addr_o    (m_addr_o),
        .m_wdata_o   (m_wdata_o),
        .m_ack_i     (m_ack_i),
        .m_rdata_i   (m_rdata_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
`ifdef ARB_PERF_EN
        ,
        .if_wait_cnt_o  (if_wait_cnt),
        .mem_wait_cnt_o (mem_wait_cnt),
        .conflict_cnt_o (conflict_cnt),
        .drop_cnt_o     (drop_cnt)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem [0:255];
    int          ack_delay = 0;   // cycles after m_valid_o rises; -1 = never

    initial begin : responder
        int rcnt;
        rcnt      = 0;
        m_ack_i   = 1'b0;
        m_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            m_ack_i   = 1'b0;
            m_rdata_i = '0;
            if (!m_valid_o) begin
                rcnt = 0;
            end else begin
                if (rcnt == ack_delay) begin
                    m_ack_i = 1'b1;
                    if (m_we_o) begin
                        for (int b = 0; b < 4; b++) begin
                            if (m_be_o[b]) mem[m_addr_o[9:2]][8*b +: 8] = m_wdata_o[8*b +: 8];
                        end
                    end else begin
                        m_rdata_i = mem[m_addr_o[9:2]];
                    end
                end
                rcnt++;
            end
        end
    end

    // ---------------- reference model (one outstanding transaction) ----------------
    int          md_src = 0;      // 0 none, 1 data port, 2 fetch port
    bit          md_discard = 0;
    int          md_age = 0;      // busy cycles elapsed for the current transaction
    bit          md_we = 0;
    logic [3:0]  md_be = '0;
    logic [31:0] md_addr = '0, md_wdata = '0;
    bit          e_if_ready = 0, e_mem_ready = 0, e_err = 0;
    logic [31:0] e_if_rdata = '0, e_mem_rdata = '0;

    initial begin : model
        bit nif, nmem, finished;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                md_src = 0; md_discard = 0; md_age = 0; md_we = 0; md_be = '0;
                md_addr = '0; md_wdata = '0; e_if_ready = 0; e_mem_ready = 0; e_err = 0;
                e_if_rdata = '0; e_mem_rdata = '0;
            end else begin
                nif  = 0;
                nmem = 0;
                if (md_src != 0) begin
                    md_age++;
                    finished = m_ack_i || (md_age == MAX_WAIT);
                    if (!m_ack_i && (md_age == MAX_WAIT)) e_err = 1;
                    if (md_src == 2 && if_abort_i) md_discard = 1;
                    if (finished) begin
                        if (md_src == 1) begin
                            nmem = 1;
                            if (!md_we) e_mem_rdata = m_ack_i ? m_rdata_i : 32'h0;
                        end else if (!md_discard) begin
                            nif        = 1;
                            e_if_rdata = m_ack_i ? m_rdata_i : 32'h0;
                        end
                        md_src = 0;
                    end
                end else if (mem_req_i && !e_mem_ready) begin
                    md_src = 1; md_discard = 0; md_age = 0; md_we = mem_we_i;
                    md_be = mem_we_i ? mem_be_i : 4'b0000;
                    md_addr = mem_addr_i; md_wdata = mem_wdata_i;
                end else if (if_req_i && !if_abort_i && !e_if_ready) begin
                    md_src = 2; md_discard = 0; md_age = 0; md_we = 0; md_be = 4'b0000;
                    md_addr = if_addr_i; md_wdata = '0;
                end
                e_if_ready  = nif;
                e_mem_ready = nmem;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin : compare
        bit e_stall;
        forever begin
            @(negedge clk);
            e_stall = rst_n && ((if_req_i && !e_if_ready && !if_abort_i) ||
                                (mem_req_i && !e_mem_ready));
            check("m_valid", m_valid_o, md_src != 0);
            if (md_src != 0) begin
                check("m_we", m_we_o, md_we);
                check("m_be", m_be_o, md_be);
                check("m_addr", m_addr_o, md_addr);
                if (md_we) check("m_wdata", m_wdata_o, md_wdata);
            end
            check("if_ready", if_ready_o, e_if_ready);
            check("mem_ready", mem_ready_o, e_mem_ready);
            check("if_rdata", if_rdata_o, e_if_rdata);
            check("mem_rdata", mem_rdata_o, e_mem_rdata);
            check("err", err_o, e_err);
            check("stall", stall_o, e_stall);
        end
    end

    // Requests must be held until ready (fetch may also leave via abort).
    mem_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        $fell(mem_req_i) |-> $past(mem_ready_o));
    if_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        $fell(if_req_i) |-> (if_abort_i || $past(if_abort_i) || $past(if_ready_o)));

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the current requests until each sees ready; report the cycle of each pulse.
    task automatic run_reqs(input int budget, input int base, output int if_cyc,
                            output int mem_cyc);
        bit if_pend, mem_pend;
        int c;
        if_pend  = if_req_i;
        mem_pend = mem_req_i;
        if_cyc   = -1;
        mem_cyc  = -1;
        c        = base;
        while ((if_pend || mem_pend) && (c < base + budget)) begin
            @(negedge clk);
            if (if_pend && if_ready_o) begin if_pend = 0; if_cyc = c; end
            if (mem_pend && mem_ready_o) begin mem_pend = 0; mem_cyc = c; end
            step();
            if (!if_pend) if_req_i = 1'b0;
            if (!mem_pend) mem_req_i = 1'b0;
            c++;
        end
        n_vec++;
        if (if_pend || mem_pend) begin
            n_miss++;
            $display("FAIL handshake: if pending %0d, mem pending %0d after %0d cycles, required 0",
                     if_pend, mem_pend, budget);
            if_req_i  = 1'b0;
            mem_req_i = 1'b0;
        end
    endtask

    initial begin : stim
        int ic, mc;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        mem[0]  = 32'h0050_0093;
        mem[65] = 32'h1234_5678;     // 0x104
        rst_n = 1'b0;
        if_req_i = 0; if_abort_i = 0; if_addr_i = '0;
        mem_req_i = 0; mem_we_i = 0; mem_be_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        check("reset m_valid", m_valid_o, 0);
        check("reset err", err_o, 0);

        // Fetch from 0x0 with a zero-wait memory.
        ack_delay = 0; if_addr_i = 32'h0; if_req_i = 1;
        @(negedge clk); check("t1 c0 stall", stall_o, 1);
        step(); @(negedge clk);
        check("t1 c1 m_valid", m_valid_o, 1); check("t1 c1 m_addr", m_addr_o, 32'h0);
        check("t1 c1 stall", stall_o, 1);
        step(); @(negedge clk);
        check("t1 c2 if_ready", if_ready_o, 1); check("t1 c2 if_rdata", if_rdata_o, 32'h0050_0093);
        check("t1 c2 stall", stall_o, 0);
        step(); if_req_i = 0;
        step();

        // Simultaneous store and fetch: store first, fetch after one bubble.
        if_addr_i = 32'h8; if_req_i = 1;
        mem_req_i = 1; mem_we_i = 1; mem_be_i = 4'hF; mem_addr_i = 32'h100;
        mem_wdata_i = 32'hDEAD_BEEF;
        step(); @(negedge clk);
        check("t2 c1 m_we", m_we_o, 1); check("t2 c1 m_be", m_be_o, 4'hF);
        check("t2 c1 m_addr", m_addr_o, 32'h100);
        step();
        run_reqs(20, 2, ic, mc);
        check("t2 mem ready cycle", mc, 2); check("t2 fetch ready cycle", ic, 4);
        check("t2 stored word", mem[64], 32'hDEAD_BEEF);
        check("t2 fetch data", if_rdata_o, 32'hA500_0002);
        step();

        // Fetch aborted while the memory is 3 cycles late.
        ack_delay = 3; if_addr_i = 32'hC; if_req_i = 1;
        step(); step();
        if_req_i = 0; if_abort_i = 1;
        @(negedge clk); check("t3 c2 stall", stall_o, 0);
        step(); if_abort_i = 0;
        @(negedge clk); check("t3 c3 m_valid", m_valid_o, 1); check("t3 c3 if_ready", if_ready_o, 0);
        step(); @(negedge clk); check("t3 c4 m_valid", m_valid_o, 1);
        step(); @(negedge clk);
        check("t3 c5 m_valid", m_valid_o, 0); check("t3 c5 if_ready", if_ready_o, 0);
        step();

        // Abort in the ack cycle: abort wins.
        ack_delay = 2; if_addr_i = 32'h10; if_req_i = 1;
        step(); step(); step();
        if_req_i = 0; if_abort_i = 1;
        step(); if_abort_i = 0;
        @(negedge clk);
        check("t3b if_ready", if_ready_o, 0); check("t3b m_valid", m_valid_o, 0);
        step();

        // Load from 0x104 acked 4 cycles late (byte enables must read as 0000).
        ack_delay = 4; mem_req_i = 1; mem_we_i = 0; mem_be_i = 4'hF; mem_addr_i = 32'h104;
        run_reqs(30, 0, ic, mc);
        check("t4 ready cycle", mc, 6); check("t4 rdata", mem_rdata_o, 32'h1234_5678);
        step();

        // Memory never acks: forced completion, rdata 0, sticky err.
        ack_delay = -1; mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h104;
        run_reqs(40, 0, ic, mc);
        check("t5 ready cycle", mc, MAX_WAIT + 1); check("t5 rdata", mem_rdata_o, 32'h0);
        check("t5 err", err_o, 1);
        ack_delay = 0; if_addr_i = 32'h4; if_req_i = 1;
        run_reqs(20, 0, ic, mc);
        check("t5 fetch cycle", ic, 2); check("t5 fetch data", if_rdata_o, 32'hA500_0001);
        check("t5 err sticky", err_o, 1);
        step();

        // Load arriving during a fetch waits for the fetch to complete.
        ack_delay = 2; if_addr_i = 32'h14; if_req_i = 1;
        step();
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h100;
        run_reqs(30, 1, ic, mc);
        check("t6 fetch cycle", ic, 4); check("t6 load cycle", mc, 8);
        check("t6 load data", mem_rdata_o, 32'hDEAD_BEEF);
        step();

        // Asynchronous reset in the middle of a MEM access.
        ack_delay = -1; mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h0;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("t7 m_valid", m_valid_o, 0); check("t7 mem_ready", mem_ready_o, 0);
        check("t7 mem_rdata", mem_rdata_o, 32'h0); check("t7 if_rdata", if_rdata_o, 32'h0);
        check("t7 err", err_o, 0); check("t7 stall", stall_o, 0);
        mem_req_i = 0;
        step(); step();
        #2 rst_n = 1'b1;
        step();
        check("t7 idle after release", m_valid_o, 0);
        ack_delay = 0; if_addr_i = 32'h0; if_req_i = 1;
        run_reqs(20, 0, ic, mc);
        check("t7 fetch cycle", ic, 2); check("t7 fetch data", if_rdata_o, 32'h0050_0093);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the pipeline's IF fetch port and MEM load/store port. Arbitrates requests and sequences each transaction through a variable-latency memory handshake. Generates the pipeline stall that feeds the core's stall_i input, and handles fetch aborts on branch/jump taken. Sits between risc_rv32i's fetch/MEM stages and the external memory model.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width (fixed 32 for RV32I)
MAX_WAIT, 15, memory ack timeout in cycles; timeout completes transaction with rdata 0 and err flag

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request, held until if_ready_o or if_abort_i
if_addr_i  in  ADDR_W  fetch address (word aligned)
if_abort_i  in  1  branch/jump taken; discard pending/in-flight fetch
if_ready_o  out  1  one-cycle pulse: if_rdata_o valid
if_rdata_o  out  DATA_W  instruction word
mem_req_i  in  1  data request, held until mem_ready_o
mem_we_i  in  1  1=store, 0=load
mem_be_i  in  4  byte enables for stores
mem_addr_i  in  ADDR_W  data address
mem_wdata_i  in  DATA_W  store data
mem_ready_o  out  1  one-cycle pulse: access done / mem_rdata_o valid
mem_rdata_o  out  DATA_W  load data (full word; MEM stage extracts)
m_valid_o  out  1  memory transaction active
m_we_o  out  1  memory write
m_be_o  out  4  memory byte enables (0000 on reads)
m_addr_o  out  ADDR_W  memory address
m_wdata_o  out  DATA_W  memory write data
m_ack_i  in  1  memory completion pulse; m_rdata_i valid same cycle
m_rdata_i  in  DATA_W  memory read data
stall_o  out  1  pipeline stall
err_o  out  1  sticky: a timeout occurred; cleared only by reset

Behaviour:
- Reset (rst_i=0, async): state IDLE; all outputs 0; wait counter 0.
- FSM states: IDLE, MEM_BUSY, IF_BUSY, IF_DROP.
- IDLE: mem_req_i has priority (older instruction). If mem_req_i=1, latch MEM request into m_* regs and go MEM_BUSY. Else if if_req_i=1 and if_abort_i=0, latch fetch and go IF_BUSY. m_* outputs are registered and valid from the cycle after acceptance. Minimum latency is 2 cycles from req to ready with a 0-wait memory.
- MEM_BUSY: m_valid_o=1, m_* held stable. On m_ack_i: mem_ready_o=1 for one cycle, mem_rdata_o=m_rdata_i (loads; held at last value after), go IDLE.
- IF_BUSY: on m_ack_i: if_ready_o=1, if_rdata_o=m_rdata_i, go IDLE. If if_abort_i=1 before ack: go IF_DROP (the memory transaction cannot be cancelled).
- IF_DROP: m_valid_o stays 1. On m_ack_i: no if_ready_o, data discarded, go IDLE.
- Abort and ack in the same cycle in IF_BUSY: abort wins; no if_ready_o; go IDLE.
- Back-to-back: ready cycle returns to IDLE; a new grant occurs next cycle (one idle bubble on m_valid_o is required).
- Wait counter: resets on every grant and increments each cycle in a BUSY/DROP state without ack. At MAX_WAIT it forces completion: ready pulse (not in IF_DROP), rdata=0, err_o set, go IDLE.
- stall_o = (if_req_i & ~if_ready_o & ~if_abort_i) | (mem_req_i & ~mem_ready_o). Combinational.
- A mem_req_i arriving during IF_BUSY waits; it is granted in the IDLE cycle after the fetch completes.
- A request deasserted without ready (other than via abort) is a protocol violation; the bench flags it with an assertion.

Optional Feature:
ARB_PERF_EN: when defined, adds 32-bit saturating counters if_wait_cnt_o, mem_wait_cnt_o (cycles each req is high without ready), conflict_cnt_o (IDLE cycles with both reqs high) and drop_cnt_o (IF_DROP entries), all reset to 0. When undefined, these ports and logic are absent.

Decomposition:
- Shared package arb_pkg: state encoding (IDLE=2'd0, MEM_BUSY=2'd1, IF_BUSY=2'd2, IF_DROP=2'd3) and the BE_NONE=4'b0000 constant.
- One sub-module, arb_wait_timer: counter plus timeout compare, parameterised by MAX_WAIT.

Test Plan:
- Fetch only, memory acks 0 cycles after m_valid_o: if_req at 0x0 -> m_addr_o=0x0 next cycle; if_ready_o with rdata 0x00500093 at cycle 2; stall_o=1 for cycles 0–1.
- if_req and mem_req (store 0xDEADBEEF to 0x100, be=1111) in the same cycle -> store granted first (m_we_o=1, m_be_o=1111); fetch granted on the IDLE cycle after mem_ready_o.
- if_abort_i during IF_BUSY with ack delayed 3 cycles -> IF_DROP; m_valid_o held until ack; no if_ready_o; then IDLE.
- Load with ack 4 cycles late from 0x104 -> mem_ready_o pulse with 0x12345678; stall_o high throughout the wait.
- Never ack, MAX_WAIT=15 -> forced ready with rdata 0 at 15 cycles after grant; err_o=1 and sticky.
- Reset asserted mid-MEM_BUSY -> all outputs 0 immediately (async); state IDLE after release.
